// File: rtl/alu_sequencer.sv
// Multi-cycle controller for the 4-bit combinational ALU: register file, command handshake,
// repeat/feedback sequencing. Optional result-zero flag built when ALU_SEQ_ZFLAG_EN is defined.
module alu_sequencer #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [2:0]   cmd_mode,
    input  logic [1:0]   cmd_dst,
    input  logic [1:0]   cmd_srca,
    input  logic [1:0]   cmd_srcb,
    input  logic [3:0]   cmd_count,
    input  logic         ld_en,
    input  logic [1:0]   ld_addr,
    input  logic [N-1:0] ld_data,
    input  logic [1:0]   rd_addr,
    output logic [N-1:0] rd_data,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [2:0]   alu_mode,
    input  logic [N-1:0] alu_result,
    output logic         busy,
    output logic         done,
    output logic         zero
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OPER = 2'd1,
        ST_WB   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   regs_q [4];
    logic [N-1:0]   regs_d [4];
    logic [2:0]     mode_q, mode_d;
    logic [1:0]     dst_q, dst_d;
    logic [1:0]     srca_q, srca_d;
    logic [1:0]     srcb_q, srcb_d;
    logic [3:0]     count_q, count_d;
    logic           first_q, first_d;
    logic [N-1:0]   alu_a_q, alu_a_d;
    logic [N-1:0]   alu_b_q, alu_b_d;
    logic [2:0]     alu_mode_q, alu_mode_d;
`ifdef ALU_SEQ_ZFLAG_EN
    logic           zero_q, zero_d;
`endif

    // Ready is masked by rst so no command can be accepted while reset is being applied.
    assign cmd_ready = (state_q == ST_IDLE) && !rst;
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign rd_data   = regs_q[rd_addr];
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_mode  = alu_mode_q;
`ifdef ALU_SEQ_ZFLAG_EN
    assign zero      = zero_q;
`else
    assign zero      = 1'b0;
`endif

    // Next-state and datapath computation for the sequencer.
    always_comb begin
        state_d    = state_q;
        regs_d     = regs_q;
        mode_d     = mode_q;
        dst_d      = dst_q;
        srca_d     = srca_q;
        srcb_d     = srcb_q;
        count_d    = count_q;
        first_d    = first_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_mode_d = alu_mode_q;
`ifdef ALU_SEQ_ZFLAG_EN
        zero_d     = zero_q;
`endif
        case (state_q)
            ST_IDLE: begin
                // A same-cycle load lands before OPER reads the register file.
                if (ld_en) begin
                    regs_d[ld_addr] = ld_data;
                end else begin
                    regs_d[ld_addr] = regs_q[ld_addr];
                end
                if (cmd_valid) begin
                    mode_d  = cmd_mode;
                    dst_d   = cmd_dst;
                    srca_d  = cmd_srca;
                    srcb_d  = cmd_srcb;
                    count_d = cmd_count;
                    first_d = 1'b1;
                    state_d = ST_OPER;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_OPER: begin
                // Later iterations feed the previous result back as operand A.
                alu_a_d    = first_q ? regs_q[srca_q] : regs_q[dst_q];
                alu_b_d    = regs_q[srcb_q];
                alu_mode_d = mode_q;
                state_d    = ST_WB;
            end
            ST_WB: begin
                regs_d[dst_q] = alu_result;
                first_d       = 1'b0;
`ifdef ALU_SEQ_ZFLAG_EN
                zero_d        = (alu_result == {N{1'b0}});
`endif
                if (count_q == 4'd0) begin
                    state_d = ST_DONE;
                end else begin
                    count_d = count_q - 4'd1;
                    state_d = ST_OPER;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            for (int i = 0; i < 4; i++) begin
                regs_q[i] <= {N{1'b0}};
            end
            mode_q     <= 3'd0;
            dst_q      <= 2'd0;
            srca_q     <= 2'd0;
            srcb_q     <= 2'd0;
            count_q    <= 4'd0;
            first_q    <= 1'b0;
            alu_a_q    <= {N{1'b0}};
            alu_b_q    <= {N{1'b0}};
            alu_mode_q <= 3'd0;
`ifdef ALU_SEQ_ZFLAG_EN
            zero_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            regs_q     <= regs_d;
            mode_q     <= mode_d;
            dst_q      <= dst_d;
            srca_q     <= srca_d;
            srcb_q     <= srcb_d;
            count_q    <= count_d;
            first_q    <= first_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_mode_q <= alu_mode_d;
`ifdef ALU_SEQ_ZFLAG_EN
            zero_q     <= zero_d;
`endif
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural 4-bit ALU attached to its drive outputs.
module tb_alu_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_mode;
    logic [1:0] cmd_dst, cmd_srca, cmd_srcb;
    logic [3:0] cmd_count;
    logic       ld_en;
    logic [1:0] ld_addr;
    logic [3:0] ld_data;
    logic [1:0] rd_addr;
    logic [3:0] rd_data;
    logic [3:0] alu_a, alu_b;
    logic [2:0] alu_mode;
    logic [3:0] alu_result;
    logic       busy, done, zero;

    int n_cmp = 0;
    int n_err = 0;

    alu_sequencer #(.N(4)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_mode(cmd_mode), .cmd_dst(cmd_dst), .cmd_srca(cmd_srca), .cmd_srcb(cmd_srcb),
        .cmd_count(cmd_count),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_mode(alu_mode), .alu_result(alu_result),
        .busy(busy), .done(done), .zero(zero)
    );

    always #5 clk = ~clk;

    // Behavioural combinational ALU.
    always_comb begin
        case (alu_mode)
            3'b000:  alu_result = alu_a + alu_b;
            3'b001:  alu_result = alu_a - alu_b;
            3'b010:  alu_result = alu_a & alu_b;
            3'b011:  alu_result = alu_a | alu_b;
            3'b100:  alu_result = alu_a ^ alu_b;
            3'b101:  alu_result = ~alu_a;
            3'b110:  alu_result = alu_a + 4'd1;
            default: alu_result = alu_a - 4'd1;
        endcase
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reg(input string tag, input logic [1:0] a, input logic [3:0] exp);
        rd_addr = a;
        #1;
        check(tag, {28'd0, rd_data}, {28'd0, exp});
    endtask

    task automatic load(input logic [1:0] a, input logic [3:0] v);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = v;
        step();
        ld_en   = 1'b0;
    endtask

    task automatic run_cmd(input string tag, input logic [2:0] m, input logic [1:0] d,
                           input logic [1:0] sa, input logic [1:0] sb, input logic [3:0] c,
                           input int exp_lat, input logic [3:0] exp_val);
        int w;
        int cyc;
        w = 0;
        while (!cmd_ready && w < 20) begin
            step();
            w++;
        end
        cmd_mode  = m;
        cmd_dst   = d;
        cmd_srca  = sa;
        cmd_srcb  = sb;
        cmd_count = c;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        ld_en     = 1'b0;
        cyc = 1;
        while (!done && cyc < 60) begin
            step();
            cyc++;
        end
        check({tag, " latency"}, cyc, exp_lat);
        step();
        check({tag, " done pulse width"}, {31'd0, done}, 32'd0);
        check({tag, " ready after done"}, {31'd0, cmd_ready}, 32'd1);
        chk_reg({tag, " result"}, d, exp_val);
    endtask

    initial begin
        logic exp_zero;
        int   cyc;
        rst = 1'b1; cmd_valid = 1'b0; cmd_mode = 3'd0; cmd_dst = 2'd0; cmd_srca = 2'd0;
        cmd_srcb = 2'd0; cmd_count = 4'd0; ld_en = 1'b0; ld_addr = 2'd0; ld_data = 4'd0;
        rd_addr = 2'd0;
        step();
        step();
        check("rst cmd_ready", {31'd0, cmd_ready}, 32'd0);
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst done", {31'd0, done}, 32'd0);
        check("rst zero", {31'd0, zero}, 32'd0);
        check("rst alu_a", {28'd0, alu_a}, 32'd0);
        check("rst alu_b", {28'd0, alu_b}, 32'd0);
        check("rst alu_mode", {29'd0, alu_mode}, 32'd0);
        rst = 1'b0;
        #1;
        check("idle cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk_reg("rst R0", 2'd0, 4'h0);
        chk_reg("rst R3", 2'd3, 4'h0);

        // 3 + 5 = 8
        load(2'd0, 4'd3);
        load(2'd1, 4'd5);
        run_cmd("add1", 3'b000, 2'd2, 2'd0, 2'd1, 4'd0, 3, 4'h8);
        check("add1 zero", {31'd0, zero}, 32'd0);

        // 3+3 then +3 repeatedly: 6,9,12,15 ; count=4 wraps to 18 mod 16 = 2
        load(2'd1, 4'd3);
        run_cmd("add rep3", 3'b000, 2'd2, 2'd0, 2'd1, 4'd3, 9, 4'hF);
        run_cmd("add rep4 wrap", 3'b000, 2'd2, 2'd0, 2'd1, 4'd4, 11, 4'h2);

        // 0 - 1 = F, then F ^ F = 0
        load(2'd0, 4'd0);
        run_cmd("dec", 3'b111, 2'd0, 2'd0, 2'd0, 4'd0, 3, 4'hF);
        run_cmd("xor", 3'b100, 2'd1, 2'd0, 2'd0, 4'd0, 3, 4'h0);
        check("xor alu_mode", {29'd0, alu_mode}, 32'd4);
`ifdef ALU_SEQ_ZFLAG_EN
        exp_zero = 1'b1;
`else
        exp_zero = 1'b0;
`endif
        check("xor zero", {31'd0, zero}, {31'd0, exp_zero});

        // Busy command (R0=F,R1=0 -> R2=F) with load and held command presented meanwhile
        cmd_mode = 3'b000; cmd_dst = 2'd2; cmd_srca = 2'd0; cmd_srcb = 2'd1; cmd_count = 4'd2;
        cmd_valid = 1'b1;
        step();
        ld_en = 1'b1; ld_addr = 2'd3; ld_data = 4'hA;
        cmd_mode = 3'b110; cmd_dst = 2'd3; cmd_srca = 2'd3; cmd_srcb = 2'd3; cmd_count = 4'd0;
        cyc = 1;
        while (!done && cyc < 40) begin
            check("held ready low", {31'd0, cmd_ready}, 32'd0);
            step();
            cyc++;
        end
        check("busy cmd latency", cyc, 7);
        chk_reg("ignored load R3", 2'd3, 4'h0);
        chk_reg("busy cmd R2", 2'd2, 4'hF);
        ld_en = 1'b0;
        step();
        check("held ready high", {31'd0, cmd_ready}, 32'd1);
        check("held idle busy", {31'd0, busy}, 32'd0);
        step();
        cmd_valid = 1'b0;
        check("held accepted busy", {31'd0, busy}, 32'd1);
        cyc = 1;
        while (!done && cyc < 40) begin
            step();
            cyc++;
        end
        check("held latency", cyc, 3);
        step();
        chk_reg("held result R3", 2'd3, 4'h1);

        // Reset in WB of iteration 1 of a count=3 command
        cmd_mode = 3'b110; cmd_dst = 2'd2; cmd_srca = 2'd0; cmd_srcb = 2'd1; cmd_count = 4'd3;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        step();
        step();
        step();
        check("abort pre busy", {31'd0, busy}, 32'd1);
        check("abort pre alu_mode", {29'd0, alu_mode}, 32'd6);
        rst = 1'b1;
        #1;
        check("abort rst ready", {31'd0, cmd_ready}, 32'd0);
        step();
        rst = 1'b0;
        #1;
        check("abort busy", {31'd0, busy}, 32'd0);
        check("abort done", {31'd0, done}, 32'd0);
        check("abort alu_mode", {29'd0, alu_mode}, 32'd0);
        check("abort alu_a", {28'd0, alu_a}, 32'd0);
        check("abort ready", {31'd0, cmd_ready}, 32'd1);
        chk_reg("abort R0", 2'd0, 4'h0);
        chk_reg("abort R1", 2'd1, 4'h0);
        chk_reg("abort R2", 2'd2, 4'h0);
        chk_reg("abort R3", 2'd3, 4'h0);
        for (int i = 0; i < 6; i++) begin
            step();
            check("abort no done", {31'd0, done}, 32'd0);
        end

        // Same-cycle load R0=7 and accept of not A -> R1 = 8
        ld_en = 1'b1; ld_addr = 2'd0; ld_data = 4'd7;
        run_cmd("load+notA", 3'b101, 2'd1, 2'd0, 2'd2, 4'd0, 3, 4'h8);
        chk_reg("load+notA R0", 2'd0, 4'h7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle controller that sequences the 4-bit ALU datapath. It owns a small register file and accepts commands through a valid/ready handshake. For each command it drives the ALU operand and mode inputs, writes the ALU result back, and optionally repeats the operation a programmed number of times, feeding each result back as the next A operand. It sits between the microprocessor's control unit and the combinational ALU, so the ALU carries no state of its own.

## Interface
- N, 4: data width; must match the ALU's width.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  high only in IDLE; a command is accepted on a clk edge where cmd_valid && cmd_ready.
- cmd_mode  in  3  ALU mode (000 add, 001 sub, 010 and, 011 or, 100 xor, 101 not A, 110 A+1, 111 A-1).
- cmd_dst, cmd_srca, cmd_srcb  in  2 each  register-file indices.
- cmd_count  in  4  extra repetitions; the operation executes cmd_count+1 times.
- ld_en, ld_addr[1:0], ld_data[N-1:0]  in  direct register write, honoured only in IDLE.
- rd_addr  in  2 / rd_data  out  N  combinational register-file read.
- alu_a, alu_b  out  N, alu_mode  out  3  registered drive to the ALU.
- alu_result  in  N  ALU result; treated as combinational from alu_a/alu_b/alu_mode.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when a command completes.
- zero  out  1  result-zero flag (see Configuration).

## Operation
- Register file: R0..R3, N bits each; all are 0 after reset.
- States: IDLE, OPER, WB, DONE.
- IDLE:
  - On accept, latch mode, dst, srca, srcb and count into internal registers, set iteration flag first=1, and go to OPER.
  - A load and an accept in the same cycle both take effect; the load lands first, so OPER reads the loaded value.
- OPER:
  - alu_a <= first ? R[srca] : R[dst].
  - alu_b <= R[srcb].
  - alu_mode <= latched mode.
  - Go to WB.
- WB:
  - R[dst] <= alu_result, first <= 0.
  - If the remaining count is 0, go to DONE; otherwise decrement the count and go to OPER.
- DONE: done=1; go to IDLE.
- ld_en in any non-IDLE state is ignored (no write, no effect).
- cmd_valid while busy is not accepted; the command must be held until cmd_ready.
- Arithmetic is modulo 2^N. Carry/borrow is discarded: the ALU's CB_out is not used.
- For unary modes (101, 110, 111), srcb is ignored by the ALU but alu_b is still driven from R[srcb].
- When dst == srca or dst == srcb, later iterations read the updated R[dst].

## Timing
- Accept on edge 0. Iteration i (0-based) occupies OPER at cycle 2i+1 and WB at cycle 2i+2.
- DONE (done=1) is at cycle 2(count+1)+1. cmd_ready rises the next cycle.
- Minimum command period is 4 cycles (count=0).
- rd_data reflects a WB write on the cycle after the write edge.
- Reset values: cmd_ready=0 during rst, then 1 in IDLE; busy=0, done=0, zero=0, alu_a=0, alu_b=0, alu_mode=000.
- rst asserted in any state aborts the command at the next edge: state returns to IDLE, registers clear, no done pulse is issued.

## Configuration
- Macro: ALU_SEQ_ZFLAG_EN.
- Defined: zero is registered on every WB edge as (alu_result == 0), holds between commands, and clears on rst.
- Undefined: zero is tied to 0 and no flag logic is built.

## Test plan
- Load R0=3, R1=5. Command add, dst=2, srca=0, srcb=1, count=0 -> done at cycle 3 after accept; R2=8; zero=0.
- R0=3, R1=3. Add, dst=2, count=3 -> R2 goes 6, 9, 12, 15; done at cycle 9. Same command with count=4 -> R2=2 (wrap).
- R0=0. Mode 111 (A-1), dst=0, srca=0 -> R0=F. Then xor with dst=1, srca=0, srcb=0 -> R1=0, zero=1 (ALU_SEQ_ZFLAG_EN defined) or zero=0 (undefined).
- During a count=2 command, drive ld_en=1, ld_addr=3, ld_data=A and hold cmd_valid -> R3 unchanged, cmd_ready=0 until after done, then the held command is accepted.
- Assert rst in the WB cycle of iteration 1 of a count=3 command -> next cycle IDLE, all registers 0, done never pulses, alu_mode=000.
- In IDLE, same-cycle ld_en (R0=7) and accept of "not A", srca=0, dst=1 -> R1=8.
